// File: rtl/digit_classifier_pkg.sv
// Shared constants and types for the digit classifier output stage.
// Scores are signed Q2.13; the margin helper clamps the best/runner-up gap.
package digit_classifier_pkg;

  localparam int N_CLASSES  = 10;
  localparam int SCORE_W    = 16;
  localparam int PROB_DEPTH = 20;
  localparam int IDX_W      = 4;

  localparam logic [SCORE_W-1:0] FIXED_ONE  = 16'h2000;
  localparam logic [SCORE_W-1:0] SCORE_MIN  = 16'h8000;
  localparam logic [SCORE_W-1:0] MARGIN_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Difference taken one bit wider so 0x7FFF - 0x8000 cannot wrap.
  function automatic logic [SCORE_W-1:0] sat_margin(
    input logic [SCORE_W-1:0] best,
    input logic [SCORE_W-1:0] second
  );
    logic [SCORE_W:0] diff;
    diff = {best[SCORE_W-1], best} - {second[SCORE_W-1], second};
    if (diff[SCORE_W]) begin
      return '0;
    end else if (diff[SCORE_W-1]) begin
      return MARGIN_MAX;
    end else begin
      return diff[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/digit_classifier.sv
// Snapshots the network's output-layer scores on a rising ready flag, scans
// them one per clock and registers argmax, winning score and margin.
module digit_classifier
  import digit_classifier_pkg::*;
(
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                R,
  input  logic [PROB_DEPTH-1:0][SCORE_W-1:0]  Probability,
  output logic [IDX_W-1:0]                    Digit,
  output logic [SCORE_W-1:0]                  Score,
  output logic [SCORE_W-1:0]                  Margin,
  output logic                                Valid,
  output logic                                Busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_e             state_q, state_d;
  logic               r_prev_q, r_prev_d;
  logic [SCORE_W-1:0] snap_q [N_CLASSES];
  logic [SCORE_W-1:0] snap_d [N_CLASSES];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [SCORE_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IDX_W-1:0]   digit_q, digit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] margin_q, margin_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] cur_s;

  // The core drives a wider array than we classify; the tail is ignored.
  logic unused_prob;
  assign unused_prob = ^Probability[PROB_DEPTH-1:N_CLASSES];

  always_comb begin
    state_d    = state_q;
    r_prev_d   = R;
    snap_d     = snap_q;
    idx_d      = idx_q;
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    score_d    = score_q;
    margin_d   = margin_q;
    valid_d    = 1'b0;
    cur_s      = snap_q[idx_q];

    case (state_q)
      IDLE: begin
        if (R && !r_prev_q) begin
          for (int i = 0; i < N_CLASSES; i++) begin
            snap_d[i] = Probability[i];
          end
          idx_d      = '0;
          best_d     = SCORE_MIN;
          second_d   = SCORE_MIN;
          best_idx_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lower index on ties; the tie lands in second.
        if ($signed(cur_s) > $signed(best_q)) begin
          second_d   = best_q;
          best_d     = cur_s;
          best_idx_d = idx_q;
        end else if ($signed(cur_s) > $signed(second_q)) begin
          second_d = cur_s;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        digit_d  = best_idx_q;
        score_d  = best_q;
        margin_d = sat_margin(best_q, second_q);
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // r_prev resets high so a ready level already present at reset release is ignored.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      r_prev_q   <= 1'b1;
      for (int i = 0; i < N_CLASSES; i++) begin
        snap_q[i] <= '0;
      end
      idx_q      <= '0;
      best_q     <= SCORE_MIN;
      second_q   <= SCORE_MIN;
      best_idx_q <= '0;
      digit_q    <= '0;
      score_q    <= '0;
      margin_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_prev_q   <= r_prev_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      second_q   <= second_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      score_q    <= score_d;
      margin_q   <= margin_d;
      valid_q    <= valid_d;
    end
  end

  assign Digit  = digit_q;
  assign Score  = score_q;
  assign Margin = margin_q;
  assign Valid  = valid_q;
  assign Busy   = (state_q != IDLE);

endmodule
